// File: rtl/screen_raster_iface.sv
// -----------------------------------------------------------------------------
// screen_raster_iface
//   Screen-side companion of the triangle drawer. Walks every pixel of an
//   inclusive bounding box in raster order (x fastest). Each pixel takes two
//   cycles: S_READ presents the framebuffer address, S_WRITE passes the
//   framebuffer read data to the drawer as old_colour and writes back the
//   drawer's new_colour. A one-cycle done pulse follows the last pixel.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   start                 : level request, sampled only while idle
//   x_min, y_min          : box origin (latched at start)
//   x_range, y_range      : box width-1 / height-1 (latched at start)
//   new_colour            : colour returned by the drawer for (x, y)
//   x, y                  : current pixel coordinate (registered)
//   old_colour            : framebuffer contents at (x, y), valid in S_WRITE
//   done                  : one-cycle pulse when the box is complete
//   busy                  : high while a box is in progress (incl. S_DONE)
//   fb_x, fb_y            : framebuffer address (equal to x, y)
//   fb_rd_data            : synchronous read data, one cycle after address
//   fb_we, fb_wr_data     : framebuffer write port
// -----------------------------------------------------------------------------
module screen_raster_iface #(
   parameter int WIDTH        = 8,
   parameter int COLOUR_WIDTH = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [COLOUR_WIDTH-1:0] new_colour,
   input  logic [WIDTH-1:0]        x_min,
   input  logic [WIDTH-1:0]        y_min,
   input  logic [WIDTH-1:0]        x_range,
   input  logic [WIDTH-1:0]        y_range,
   output logic [WIDTH-1:0]        x,
   output logic [WIDTH-1:0]        y,
   output logic [COLOUR_WIDTH-1:0] old_colour,
   output logic                    done,
   output logic                    busy,
   output logic [WIDTH-1:0]        fb_x,
   output logic [WIDTH-1:0]        fb_y,
   input  logic [COLOUR_WIDTH-1:0] fb_rd_data,
   output logic                    fb_we,
   output logic [COLOUR_WIDTH-1:0] fb_wr_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [WIDTH-1:0] dx_q, dx_d, dy_q, dy_d;
   logic [WIDTH-1:0] xmin_q, xmin_d, ymin_q, ymin_d;
   logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             we_q, we_d;

   // Next-state logic. Flags are computed for the state being entered so that
   // done/busy/fb_we come straight from registers. dx/dy count against the
   // latched ranges so the box end is found even when x or y wraps.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      xmin_d  = xmin_q;
      ymin_d  = ymin_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      we_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               xmin_d  = x_min;
               ymin_d  = y_min;
               xr_d    = x_range;
               yr_d    = y_range;
               dx_d    = '0;
               dy_d    = '0;
               x_d     = x_min;
               y_d     = y_min;
               busy_d  = 1'b1;
               state_d = S_READ;
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_READ: begin
            busy_d  = 1'b1;
            we_d    = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            busy_d = 1'b1;
            if (dx_q != xr_q) begin
               dx_d    = dx_q + WIDTH'(1);
               x_d     = x_q + WIDTH'(1);
               state_d = S_READ;
            end else if (dy_q != yr_q) begin
               dx_d    = '0;
               x_d     = xmin_q;
               dy_d    = dy_q + WIDTH'(1);
               y_d     = y_q + WIDTH'(1);
               state_d = S_READ;
            end else begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately,
   // which drops fb_we without waiting for a clock edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         xmin_q  <= '0;
         ymin_q  <= '0;
         xr_q    <= '0;
         yr_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         xmin_q  <= xmin_d;
         ymin_q  <= ymin_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         we_q    <= we_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign fb_x       = x_q;
   assign fb_y       = y_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign fb_we      = we_q;
   assign fb_wr_data = new_colour;
   // Consumers only look at old_colour in S_WRITE.
   assign old_colour = fb_rd_data;

endmodule
